// File: rtl/ccd_clock_sequencer.sv
// CCD clock-phase sequencer: runs integrate / photogate transfer / per-pixel
// shift-reset-sample frames with a programmable step length, integration time
// and pixel count. All outputs are registered from the current state, so they
// trail the state register by one clock.
module ccd_clock_sequencer #(
  parameter int unsigned DIV_W = 4,
  parameter int unsigned INT_W = 16,
  parameter int unsigned PIX_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cont_mode,
  input  logic [DIV_W-1:0] div_sel,
  input  logic [INT_W-1:0] int_time,
  input  logic [PIX_W-1:0] n_pix,
  output logic             phi_p,
  output logic             phi_l1,
  output logic             phi_l2,
  output logic             phi_r,
  output logic             adc_sample,
  output logic [PIX_W-1:0] pix_idx,
  output logic             busy,
  output logic             frame_done,
  output logic             cfg_err
);

  typedef enum logic [2:0] {StIdle, StIntegrate, StTransfer, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] pre_q, pre_d, div_q, div_d;
  logic [INT_W-1:0] step_q, step_d, int_q, int_d;
  logic [PIX_W-1:0] pix_q, pix_d, npix_q, npix_d;

  logic             phi_p_d, phi_l1_d, phi_l2_d, phi_r_d, adc_d;
  logic             busy_d, frame_done_d, cfg_err_d;
  logic [PIX_W-1:0] pix_idx_d;

  logic step_end;
  logic do_abort;

  assign step_end = (pre_q == div_q);
  assign do_abort = abort && (state_q != StIdle);

  // Next state, config latch, step prescaler and step/pixel counters
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q + DIV_W'(1);
    step_d  = step_q;
    pix_d   = pix_q;
    div_d   = div_q;
    int_d   = int_q;
    npix_d  = npix_q;
    unique case (state_q)
      StIdle: begin
        pre_d  = '0;
        step_d = '0;
        pix_d  = '0;
        if (start && (n_pix != '0) && (int_time != '0)) begin
          div_d   = div_sel;
          int_d   = int_time;
          npix_d  = n_pix;
          state_d = StIntegrate;
        end
      end
      StIntegrate: begin
        if (step_end) begin
          pre_d = '0;
          if (step_q == int_q - INT_W'(1)) begin
            step_d  = '0;
            state_d = StTransfer;
          end else begin
            step_d = step_q + INT_W'(1);
          end
        end
      end
      StTransfer: begin
        if (step_end) begin
          pre_d = '0;
          if (step_q[0]) begin
            step_d  = '0;
            pix_d   = '0;
            state_d = StShift;
          end else begin
            step_d = step_q + INT_W'(1);
          end
        end
      end
      StShift: begin
        if (step_end) begin
          pre_d = '0;
          if (step_q[1:0] == 2'd3) begin
            step_d = '0;
            if (pix_q == npix_q - PIX_W'(1)) state_d = StDone;
            else                             pix_d   = pix_q + PIX_W'(1);
          end else begin
            step_d = step_q + INT_W'(1);
          end
        end
      end
      StDone: begin
        pre_d   = '0;
        step_d  = '0;
        pix_d   = '0;
        state_d = cont_mode ? StIntegrate : StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (do_abort) begin
      state_d = StIdle;
      pre_d   = '0;
      step_d  = '0;
      pix_d   = '0;
    end
  end

  // Output decode from the current state; abort clears everything at once
  always_comb begin
    phi_p_d      = 1'b0;
    phi_l1_d     = 1'b0;
    phi_l2_d     = 1'b0;
    phi_r_d      = 1'b0;
    adc_d        = 1'b0;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;
    pix_idx_d    = '0;
    cfg_err_d    = (state_q == StIdle) && start && ((n_pix == '0) || (int_time == '0));
    case (state_q)
      StIntegrate: begin
        busy_d   = 1'b1;
        phi_l1_d = 1'b1;
      end
      StTransfer: begin
        busy_d   = 1'b1;
        phi_p_d  = 1'b1;
        phi_l1_d = ~step_q[0];
      end
      StShift: begin
        busy_d    = 1'b1;
        pix_idx_d = pix_q;
        unique case (step_q[1:0])
          2'd0: begin
            phi_r_d  = 1'b1;
            phi_l1_d = 1'b1;
          end
          2'd1: phi_l1_d = 1'b1;
          2'd2: phi_l2_d = 1'b1;
          2'd3: begin
            phi_l2_d = 1'b1;
            // strobe only on the first clock of the step
            adc_d    = (pre_q == '0);
          end
          default: ;
        endcase
      end
      StDone: begin
        busy_d       = 1'b1;
        frame_done_d = 1'b1;
      end
      default: ;
    endcase
    if (do_abort) begin
      phi_p_d      = 1'b0;
      phi_l1_d     = 1'b0;
      phi_l2_d     = 1'b0;
      phi_r_d      = 1'b0;
      adc_d        = 1'b0;
      busy_d       = 1'b0;
      frame_done_d = 1'b0;
      pix_idx_d    = '0;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pre_q      <= '0;
      step_q     <= '0;
      pix_q      <= '0;
      div_q      <= '0;
      int_q      <= '0;
      npix_q     <= '0;
      phi_p      <= 1'b0;
      phi_l1     <= 1'b0;
      phi_l2     <= 1'b0;
      phi_r      <= 1'b0;
      adc_sample <= 1'b0;
      pix_idx    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      step_q     <= step_d;
      pix_q      <= pix_d;
      div_q      <= div_d;
      int_q      <= int_d;
      npix_q     <= npix_d;
      phi_p      <= phi_p_d;
      phi_l1     <= phi_l1_d;
      phi_l2     <= phi_l2_d;
      phi_r      <= phi_r_d;
      adc_sample <= adc_d;
      pix_idx    <= pix_idx_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      cfg_err    <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_ccd_clock_sequencer.sv
// Bench for ccd_clock_sequencer: expected per-clock output vectors are built
// from the frame recipe (phase durations in steps) and compared every clock.
module tb_ccd_clock_sequencer;

  localparam int unsigned DIV_W = 4;
  localparam int unsigned INT_W = 16;
  localparam int unsigned PIX_W = 10;

  // {cfg_err, busy, phi_p, phi_l1, phi_l2, phi_r, adc_sample, frame_done, pix_idx}
  typedef logic [PIX_W+7:0] vec_t;

  typedef struct {
    int div;
    int it;
    int np;
    int exp_len;
  } frame_row_t;

  typedef struct {
    int it;
    int np;
  } bad_row_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             cont_mode = 1'b0;
  logic [DIV_W-1:0] div_sel = '0;
  logic [INT_W-1:0] int_time = '0;
  logic [PIX_W-1:0] n_pix = '0;
  logic             phi_p, phi_l1, phi_l2, phi_r, adc_sample, busy, frame_done, cfg_err;
  logic [PIX_W-1:0] pix_idx;
  vec_t             act_v;

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t exp_q[$];

  assign act_v = {cfg_err, busy, phi_p, phi_l1, phi_l2, phi_r, adc_sample, frame_done, pix_idx};

  ccd_clock_sequencer #(.DIV_W(DIV_W), .INT_W(INT_W), .PIX_W(PIX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .cont_mode (cont_mode),
    .div_sel   (div_sel),
    .int_time  (int_time),
    .n_pix     (n_pix),
    .phi_p     (phi_p),
    .phi_l1    (phi_l1),
    .phi_l2    (phi_l2),
    .phi_r     (phi_r),
    .adc_sample(adc_sample),
    .pix_idx   (pix_idx),
    .busy      (busy),
    .frame_done(frame_done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  // Phase non-overlap invariants, checked every clock out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if ((phi_l1 && phi_l2) || (phi_p && phi_l2)) begin
        n_err++;
        $display("FAIL overlap: p=%0b l1=%0b l2=%0b required no l1&l2, no p&l2",
                 phi_p, phi_l1, phi_l2);
      end
    end
  end

  function automatic vec_t mk(input logic bsy, input logic p, input logic l1, input logic l2,
                              input logic r, input logic adc, input logic fd, input int pix);
    vec_t v;
    v = {1'b0, bsy, p, l1, l2, r, adc, fd, PIX_W'(pix)};
    return v;
  endfunction

  task automatic check(input string name, input vec_t got, input vec_t want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  // Reference: one frame as a list of per-clock output vectors
  task automatic build_frame(input int div, input int it, input int np);
    int s;
    s = div + 1;
    for (int i = 0; i < it * s; i++) exp_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < s; i++)      exp_q.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < s; i++)      exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    for (int px = 0; px < np; px++) begin
      for (int i = 0; i < s; i++) exp_q.push_back(mk(1, 0, 1, 0, 1, 0, 0, px));
      for (int i = 0; i < s; i++) exp_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, px));
      for (int i = 0; i < s; i++) exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, px));
      for (int i = 0; i < s; i++) exp_q.push_back(mk(1, 0, 0, 1, 0, (i == 0), 0, px));
    end
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0));
  endtask

  // Pulse start with the given config; returns at the negedge after the start edge
  task automatic do_start(input int div, input int it, input int np);
    @(negedge clk);
    div_sel  = DIV_W'(div);
    int_time = INT_W'(it);
    n_pix    = PIX_W'(np);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Compare n clocks against the model; report the first clock with frame_done
  task automatic play(input string name, input int n, output int fd_at);
    vec_t want;
    fd_at = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      check(name, act_v, want);
      if (frame_done && fd_at == 0) fd_at = k;
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check(name, act_v, '0);
  endtask

  frame_row_t frames[4];
  bad_row_t   bads[3];
  int         fd_at;
  int         len;
  int         d, it, np;
  vec_t       ce_v;

  initial begin
    frames[0] = '{div: 0, it: 2, np: 3, exp_len: 17};
    frames[1] = '{div: 3, it: 2, np: 3, exp_len: 65};
    frames[2] = '{div: 1, it: 1, np: 1, exp_len: 15};
    frames[3] = '{div: 2, it: 4, np: 2, exp_len: 43};
    bads[0]   = '{it: 2, np: 0};
    bads[1]   = '{it: 0, np: 3};
    bads[2]   = '{it: 0, np: 0};
    ce_v      = '0;
    ce_v[PIX_W+7] = 1'b1;

    // reset state
    #12;
    check("reset_state", act_v, '0);
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("idle_after_reset");

    // directed frames
    foreach (frames[i]) begin
      exp_q.delete();
      build_frame(frames[i].div, frames[i].it, frames[i].np);
      do_start(frames[i].div, frames[i].it, frames[i].np);
      len = exp_q.size();
      play("frame_vec", len, fd_at);
      n_cmp++;
      if (fd_at != frames[i].exp_len) begin
        n_err++;
        $display("FAIL frame_len[%0d]: got %0d required %0d", i, fd_at, frames[i].exp_len);
      end
      check_idle("busy_drop");
    end

    // rejected configs
    foreach (bads[i]) begin
      do_start(0, bads[i].it, bads[i].np);
      check("cfg_err_pulse", act_v, ce_v);
      check_idle("cfg_err_clear");
    end

    // continuous mode: three frames, leave after the third
    exp_q.delete();
    for (int f = 0; f < 3; f++) build_frame(0, 1, 1);
    cont_mode = 1'b1;
    do_start(0, 1, 1);
    play("cont_vec", 20, fd_at);
    n_cmp++;
    if (fd_at != 8) begin
      n_err++;
      $display("FAIL cont_first_done: got %0d required 8", fd_at);
    end
    cont_mode = 1'b0;
    play("cont_vec_tail", 4, fd_at);
    check_idle("cont_exit");

    // abort in pixel 1, with an ignored start while busy
    exp_q.delete();
    build_frame(0, 2, 3);
    do_start(0, 2, 3);
    play("abort_pre", 2, fd_at);
    start = 1'b1;
    n_pix = '0;
    play("start_busy", 1, fd_at);
    start = 1'b0;
    play("abort_pre2", 7, fd_at);
    abort = 1'b1;
    check_idle("abort_zero");
    abort = 1'b0;
    for (int k = 0; k < 5; k++) check_idle("abort_no_done");

    // asynchronous reset mid-integrate, then a normal frame
    exp_q.delete();
    build_frame(0, 5, 2);
    do_start(0, 5, 2);
    play("rst_pre", 3, fd_at);
    #2 rst_n = 1'b0;
    #1 check("async_reset", act_v, '0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    build_frame(0, 2, 3);
    do_start(0, 2, 3);
    len = exp_q.size();
    play("post_reset", len, fd_at);
    check_idle("post_reset_idle");

    // random configs against the recipe and the frame-length formula
    for (int r = 0; r < 6; r++) begin
      d  = $urandom_range(0, 3);
      it = $urandom_range(1, 6);
      np = $urandom_range(1, 5);
      exp_q.delete();
      build_frame(d, it, np);
      do_start(d, it, np);
      len = exp_q.size();
      play("rand_vec", len, fd_at);
      n_cmp++;
      if (fd_at != 1 + (d + 1) * (it + 2 + 4 * np)) begin
        n_err++;
        $display("FAIL rand_len: got %0d required %0d", fd_at, 1 + (d + 1) * (it + 2 + 4 * np));
      end
      check_idle("rand_idle");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
